// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
//
// Purpose: register index width, FSM state encoding and flush counter width
//          shared by hazard_ctrl, its scoreboard and its bus interface.
// Ports:   none (package).
package hazard_ctrl_pkg;

  localparam int REG_ADDR_SIZE = 5;
  localparam int NUM_REGS      = 1 << REG_ADDR_SIZE;
  localparam int FCNT_W        = 4;   // holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 15

  typedef logic [REG_ADDR_SIZE-1:0] reg_addr_t;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side bus of the hazard controller
//
// Purpose: groups decode, writeback, redirect/exception inputs and the
//          stall/flush/redirect/debug outputs of hazard_ctrl.
// Ports:   master - pipeline side (drives decode/wb/ex/exc, sees stall/flush/redirect)
//          slave  - hazard_ctrl side
interface hazard_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  import hazard_ctrl_pkg::*;

  logic              dec_valid;
  reg_addr_t         dec_rs1_addr;
  reg_addr_t         dec_rs2_addr;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  reg_addr_t         dec_rd_addr;
  logic              dec_writes_rd;
  logic              wb_valid;
  reg_addr_t         wb_rd_addr;
  logic              ex_redirect;
  logic [ADDR_W-1:0] ex_target;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_vector;
  logic              stall;
  logic              flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       busy_vec;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
           dec_rd_addr, dec_writes_rd, wb_valid, wb_rd_addr,
           ex_redirect, ex_target, exc_valid, exc_vector,
    input  stall, flush, redirect_valid, redirect_pc, busy_vec, stall_count
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
           dec_rd_addr, dec_writes_rd, wb_valid, wb_rd_addr,
           ex_redirect, ex_target, exc_valid, exc_vector,
    output stall, flush, redirect_valid, redirect_pc, busy_vec, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// rtl/hazard_ctrl_scoreboard.sv - pending-write scoreboard
//
// Purpose: one busy bit per architectural register with single set, single
//          clear and bulk clear; bit 0 (x0) is never busy.
// Ports:   clk, reset            - clock, synchronous active-high reset
//          i_set_en/i_set_addr   - mark a register as pending
//          i_clr_en/i_clr_addr   - retire a pending register
//          i_bulk_clr            - drop every pending bit
//          i_rs1/rs2/rd_addr     - lookup indices
//          o_rs1/rs2/rd_busy     - lookup results
//          o_busy_vec            - all busy bits
module hazard_ctrl_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_set_en,
  input  reg_addr_t           i_set_addr,
  input  logic                i_clr_en,
  input  reg_addr_t           i_clr_addr,
  input  logic                i_bulk_clr,
  input  reg_addr_t           i_rs1_addr,
  input  reg_addr_t           i_rs2_addr,
  input  reg_addr_t           i_rd_addr,
  output logic                o_rs1_busy,
  output logic                o_rs2_busy,
  output logic                o_rd_busy,
  output logic [NUM_REGS-1:0] o_busy_vec
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Set is applied last so a same-index set and clear leaves the bit set.
  always_comb begin
    w_busy_nxt = i_bulk_clr ? '0 : r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Lookups use the registered bits only: a writeback this cycle does not
  // release a hazard until the next cycle.
  assign o_rs1_busy = r_busy[i_rs1_addr];
  assign o_rs2_busy = r_busy[i_rs2_addr];
  assign o_rd_busy  = r_busy[i_rd_addr];
  assign o_busy_vec = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - in-order pipeline hazard controller
//
// Purpose: RAW/WAW stall generation from a pending-write scoreboard,
//          multi-cycle flush with PC redirect on branch/jump or exception,
//          and a saturating stall-cycle counter.
// Ports:   clk    - clock
//          reset  - synchronous active-high reset
//          hz_bus - hazard_ctrl_if.slave: decode/wb/ex/exc inputs,
//                   stall/flush/redirect_valid/redirect_pc/busy_vec/stall_count outputs
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz_bus
);

  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  hz_state_t         r_state;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_flush;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_rs1_busy, w_rs2_busy, w_rd_busy;
  logic w_haz, w_stall, w_issue, w_redirect_req;

  assign w_haz = hz_bus.dec_valid &
                 ((hz_bus.dec_uses_rs1  & w_rs1_busy) |
                  (hz_bus.dec_uses_rs2  & w_rs2_busy) |
                  (hz_bus.dec_writes_rd & w_rd_busy));

  assign w_stall        = w_haz & ~r_flush;
  assign w_redirect_req = hz_bus.ex_redirect | hz_bus.exc_valid;
  assign w_issue        = hz_bus.dec_valid & ~w_haz & (r_state == HZ_RUN) & ~w_redirect_req;

  hazard_ctrl_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (w_issue & hz_bus.dec_writes_rd),
    .i_set_addr (hz_bus.dec_rd_addr),
    .i_clr_en   (hz_bus.wb_valid),
    .i_clr_addr (hz_bus.wb_rd_addr),
    .i_bulk_clr (hz_bus.exc_valid),
    .i_rs1_addr (hz_bus.dec_rs1_addr),
    .i_rs2_addr (hz_bus.dec_rs2_addr),
    .i_rd_addr  (hz_bus.dec_rd_addr),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_busy  (w_rd_busy),
    .o_busy_vec (hz_bus.busy_vec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= HZ_RUN;
      r_fcnt           <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      case (r_state)
        HZ_RUN: begin
          if (w_redirect_req) begin
            r_state          <= HZ_FLUSH;
            r_fcnt           <= FCNT_INIT;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= hz_bus.exc_valid ? hz_bus.exc_vector : hz_bus.ex_target;
          end
        end
        HZ_FLUSH: begin
          // ex_redirect here belongs to a squashed instruction and is dropped.
          if (hz_bus.exc_valid) begin
            r_fcnt           <= FCNT_INIT;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= hz_bus.exc_vector;
          end else if (r_fcnt == '0) begin
            r_state <= HZ_RUN;
            r_flush <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - 1'b1;
          end
        end
        default: begin
          r_state <= HZ_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          r_stall_count <= '0;
    else if (w_stall && ~&r_stall_count) r_stall_count <= r_stall_count + 1'b1;
  end

  assign hz_bus.stall          = w_stall;
  assign hz_bus.flush          = r_flush;
  assign hz_bus.redirect_valid = r_redirect_valid;
  assign hz_bus.redirect_pc    = r_redirect_pc;
  assign hz_bus.stall_count    = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int ADDR_W  = 32;
  localparam int FLUSH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .hz_bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: set of pending registers, flush cycles still to come,
  // last redirect pulse/PC and number of stalled cycles.
  bit          m_pend[32];
  int          m_flush_left;
  bit          m_rv;
  logic [31:0] m_pc;
  int          m_cnt;

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_haz();
    return bus.dec_valid &&
           ((bus.dec_uses_rs1  && m_pend[bus.dec_rs1_addr]) ||
            (bus.dec_uses_rs2  && m_pend[bus.dec_rs2_addr]) ||
            (bus.dec_writes_rd && m_pend[bus.dec_rd_addr]));
  endfunction

  function automatic bit m_stall();
    return m_haz() && (m_flush_left == 0);
  endfunction

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit haz, issue;
    haz = m_haz();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_flush_left = 0; m_rv = 1'b0; m_pc = '0; m_cnt = 0;
    end else begin
      if (haz && m_flush_left == 0 && m_cnt < CNT_MAX) m_cnt++;
      issue = bus.dec_valid && !haz && m_flush_left == 0 && !bus.ex_redirect && !bus.exc_valid;
      if (bus.exc_valid) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      if (bus.wb_valid) m_pend[bus.wb_rd_addr] = 1'b0;
      if (issue && bus.dec_writes_rd && bus.dec_rd_addr != 0) m_pend[bus.dec_rd_addr] = 1'b1;
      if (bus.exc_valid || (bus.ex_redirect && m_flush_left == 0)) begin
        m_flush_left = FLUSH;
        m_rv = 1'b1;
        m_pc = bus.exc_valid ? bus.exc_vector : bus.ex_target;
      end else begin
        m_rv = 1'b0;
        if (m_flush_left > 0) m_flush_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_rs1_addr = 0; bus.dec_rs2_addr = 0;
    bus.dec_uses_rs1 = 0; bus.dec_uses_rs2 = 0; bus.dec_rd_addr = 0;
    bus.dec_writes_rd = 0; bus.wb_valid = 0; bus.wb_rd_addr = 0;
    bus.ex_redirect = 0; bus.ex_target = 0; bus.exc_valid = 0; bus.exc_vector = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    tick(); tick();
    reset = 1'b0;
    bus.dec_valid = 1; bus.dec_uses_rs1 = 1; bus.dec_rs1_addr = 5'd3;
    #1;
    n_vec++; if (bus.busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", bus.busy_vec); end
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
    n_vec++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%b exp=0", bus.redirect_valid); end
    n_vec++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", bus.redirect_pc); end
    n_vec++; if (bus.stall_count !== 4'h0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_count); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    idle();
  endtask

  task automatic test_raw_stall();
    idle();
    bus.dec_valid = 1; bus.dec_writes_rd = 1; bus.dec_rd_addr = 5'd5;
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL raw_producer_stall got=%b exp=0", bus.stall); end
    tick();
    n_vec++; if (bus.busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL raw_busy5_set got=%b exp=1", bus.busy_vec[5]); end
    idle();
    bus.dec_valid = 1; bus.dec_uses_rs1 = 1; bus.dec_rs1_addr = 5'd5;
    #1;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL raw_consumer_stall got=%b exp=1", bus.stall); end
    tick();
    bus.wb_valid = 1; bus.wb_rd_addr = 5'd5;
    #1;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_during_wb got=%b exp=1", bus.stall); end
    tick();
    bus.wb_valid = 0;
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL raw_release got=%b exp=0", bus.stall); end
    n_vec++; if (bus.busy_vec[5] !== 1'b0) begin n_err++; $display("FAIL raw_busy5_clr got=%b exp=0", bus.busy_vec[5]); end
    tick();
    idle();
  endtask

  task automatic test_x0();
    idle();
    bus.dec_valid = 1; bus.dec_writes_rd = 1; bus.dec_rd_addr = 5'd0;
    bus.dec_uses_rs1 = 1; bus.dec_rs1_addr = 5'd0;
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL x0_stall_a got=%b exp=0", bus.stall); end
    tick();
    n_vec++; if (bus.busy_vec !== 32'h0) begin n_err++; $display("FAIL x0_busy got=%h exp=0", bus.busy_vec); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL x0_stall_b got=%b exp=0", bus.stall); end
    idle();
  endtask

  task automatic test_redirect();
    idle();
    bus.ex_redirect = 1; bus.ex_target = 32'h0000_0100;
    bus.dec_valid = 1; bus.dec_writes_rd = 1; bus.dec_rd_addr = 5'd7;
    tick();
    bus.ex_redirect = 0;
    n_vec++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL redir_rv got=%b exp=1", bus.redirect_valid); end
    n_vec++; if (bus.redirect_pc !== 32'h100) begin n_err++; $display("FAIL redir_pc got=%h exp=00000100", bus.redirect_pc); end
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL redir_flush1 got=%b exp=1", bus.flush); end
    n_vec++; if (bus.busy_vec[7] !== 1'b0) begin n_err++; $display("FAIL redir_no_issue got=%b exp=0", bus.busy_vec[7]); end
    tick();
    n_vec++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush2 got=%b/%b exp=1/0", bus.flush, bus.redirect_valid); end
    tick();
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL redir_flush_end got=%b exp=0", bus.flush); end
    n_vec++; if (bus.busy_vec[7] !== 1'b0) begin n_err++; $display("FAIL redir_no_issue_end got=%b exp=0", bus.busy_vec[7]); end
    idle();
  endtask

  task automatic test_exc_priority();
    idle();
    bus.dec_valid = 1; bus.dec_writes_rd = 1; bus.dec_rd_addr = 5'd9;
    tick();
    idle();
    bus.exc_valid = 1; bus.exc_vector = 32'h8000_0000;
    bus.ex_redirect = 1; bus.ex_target = 32'h0000_0200;
    tick();
    n_vec++; if (bus.redirect_pc !== 32'h8000_0000) begin n_err++; $display("FAIL exc_pc got=%h exp=80000000", bus.redirect_pc); end
    n_vec++; if (bus.busy_vec !== 32'h0) begin n_err++; $display("FAIL exc_busy got=%h exp=0", bus.busy_vec); end
    n_vec++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL exc_rv got=%b exp=1", bus.redirect_valid); end
    // Still flushing: ex_redirect is ignored, a second exception re-issues the redirect.
    idle();
    bus.ex_redirect = 1; bus.ex_target = 32'h0000_0444;
    tick();
    n_vec++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h8000_0000) begin n_err++; $display("FAIL flush_exr_ignored got=%b/%h exp=0/80000000", bus.redirect_valid, bus.redirect_pc); end
    idle();
    bus.exc_valid = 1; bus.exc_vector = 32'h0000_0500;
    tick();
    idle();
    n_vec++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h500) begin n_err++; $display("FAIL flush_exc_rv got=%b/%h exp=1/00000500", bus.redirect_valid, bus.redirect_pc); end
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL flush_exc_f1 got=%b exp=1", bus.flush); end
    tick();
    n_vec++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_exc_f2 got=%b/%b exp=1/0", bus.flush, bus.redirect_valid); end
    tick();
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL flush_exc_end got=%b exp=0", bus.flush); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.dec_valid     = ($urandom_range(0, 3) != 0);
      bus.dec_rs1_addr  = 5'($urandom_range(0, 7));
      bus.dec_rs2_addr  = 5'($urandom_range(0, 7));
      bus.dec_uses_rs1  = 1'($urandom);
      bus.dec_uses_rs2  = 1'($urandom);
      bus.dec_rd_addr   = 5'($urandom_range(0, 7));
      bus.dec_writes_rd = 1'($urandom);
      bus.wb_valid      = ($urandom_range(0, 2) == 0);
      bus.wb_rd_addr    = 5'($urandom_range(0, 7));
      bus.ex_redirect   = ($urandom_range(0, 11) == 0);
      bus.ex_target     = 32'($urandom);
      bus.exc_valid     = ($urandom_range(0, 39) == 0);
      bus.exc_vector    = 32'($urandom);
      #1;
      n_vec++; if (bus.stall !== m_stall()) begin n_err++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.stall, m_stall()); end
      tick();
      n_vec++; if (bus.busy_vec !== m_busy_vec()) begin n_err++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, bus.busy_vec, m_busy_vec()); end
      n_vec++; if (bus.flush !== (m_flush_left > 0)) begin n_err++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, bus.flush, m_flush_left > 0); end
      n_vec++; if (bus.redirect_valid !== m_rv) begin n_err++; $display("FAIL rnd_rv c=%0d got=%b exp=%b", c, bus.redirect_valid, m_rv); end
      n_vec++; if (bus.redirect_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, bus.redirect_pc, m_pc); end
      n_vec++; if (int'(bus.stall_count) !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.stall_count, m_cnt); end
    end
    reset = 1'b0; idle();
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_saturation();
    reset = 1'b1; idle();
    tick();
    reset = 1'b0;
    bus.dec_valid = 1; bus.dec_writes_rd = 1; bus.dec_rd_addr = 5'd3;
    tick();
    idle();
    bus.dec_valid = 1; bus.dec_uses_rs2 = 1; bus.dec_rs2_addr = 5'd3;
    for (int c = 0; c < 5; c++) tick();
    n_vec++; if (bus.stall_count !== 4'd5) begin n_err++; $display("FAIL sat_cnt5 got=%0d exp=5", bus.stall_count); end
    for (int c = 5; c < (1 << CNT_W) + 3; c++) tick();
    n_vec++; if (bus.stall_count !== 4'd15) begin n_err++; $display("FAIL sat_cnt got=%0d exp=15", bus.stall_count); end
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL sat_stall got=%b exp=1", bus.stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    #1;
    n_vec++; if (bus.stall_count !== 4'd0 || bus.busy_vec !== 32'h0 || bus.stall !== 1'b0) begin n_err++; $display("FAIL sat_reset got=%0d/%h/%b exp=0/0/0", bus.stall_count, bus.busy_vec, bus.stall); end
  endtask

  task automatic test_reset_midflush();
    idle();
    bus.ex_redirect = 1; bus.ex_target = 32'h0000_0040;
    tick();
    idle();
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL midflush_pre got=%b exp=1", bus.flush); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin n_err++; $display("FAIL midflush_reset got=%b/%b/%h exp=0/0/0", bus.flush, bus.redirect_valid, bus.redirect_pc); end
    tick();
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL midflush_after got=%b exp=0", bus.flush); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_flush_left = 0; m_rv = 1'b0; m_pc = '0; m_cnt = 0;
    test_reset();
    test_raw_stall();
    test_x0();
    test_redirect();
    test_exc_priority();
    test_random();
    test_saturation();
    test_reset_midflush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

In-order pipeline hazard controller sitting beside the decode stage. Keeps a per-register scoreboard of outstanding writes, raises `stall` to decode and fetch on read-after-write and write-after-write hazards, and sequences a multi-cycle `flush` with a PC redirect when execute resolves a taken branch or jump, or when an exception is raised. Also maintains a saturating stall-cycle performance counter.

## Interface
Parameters:
- `ADDR_W`, 32: PC width.
- `FLUSH_CYCLES`, 2: cycles `flush` stays asserted per redirect (1..15).
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `dec_valid` in 1: decode holds a valid instruction.
- `dec_rs1_addr` in 5: rs1 index.
- `dec_rs2_addr` in 5: rs2 index.
- `dec_uses_rs1` in 1: instruction reads rs1.
- `dec_uses_rs2` in 1: instruction reads rs2.
- `dec_rd_addr` in 5: destination index.
- `dec_writes_rd` in 1: instruction writes rd.
- `wb_valid` in 1: writeback retires a register write this cycle.
- `wb_rd_addr` in 5: register being written back.
- `ex_redirect` in 1: execute resolved a taken branch, JAL or JALR.
- `ex_target` in ADDR_W: redirect target.
- `exc_valid` in 1: exception reported at commit.
- `exc_vector` in ADDR_W: trap target.
- `stall` out 1: hold fetch and decode (combinational).
- `flush` out 1: squash fetch and decode (registered).
- `redirect_valid` out 1: one-cycle pulse to fetch, asserted with the first flush cycle.
- `redirect_pc` out ADDR_W: new fetch PC, valid with `redirect_valid`.
- `busy_vec` out 32: scoreboard bits, for debug.
- `stall_count` out CNT_W: saturating count of cycles with `stall` = 1.

## Operation
- Scoreboard:
  - `busy[31:1]` marks pending writes; `busy[0]` is hardwired to 0. Writes to x0 are never tracked.
- Hazard:
  - `haz` = `dec_valid` and any of:
    - `dec_uses_rs1` and `busy[rs1]`
    - `dec_uses_rs2` and `busy[rs2]`
    - `dec_writes_rd` and `busy[rd]` (WAW)
  - A `wb_valid` clear of the same register in the same cycle does NOT release the hazard. Release takes effect the next cycle, so the regfile write has already landed.
- `stall` = `haz` and not `flush`. A flush overrides a stall.
- Issue:
  - `issue` = `dec_valid` and not `haz` and state == RUN and not (`ex_redirect` or `exc_valid`).
  - On `issue` with `dec_writes_rd` and rd ≠ 0, set `busy[rd]`.
- Clear:
  - On `wb_valid` with `wb_rd_addr` ≠ 0, clear `busy[wb_rd_addr]`.
  - If the same index is set and cleared in one cycle, set wins.
- Exception:
  - On `exc_valid`, the entire scoreboard is cleared (all older work has retired or been killed), except any set by `issue`, which is blocked in that cycle anyway.
- FSM states: RUN, FLUSH.
  - RUN → FLUSH on `ex_redirect` or `exc_valid`:
    - Load the down-counter `fcnt` with FLUSH_CYCLES − 1.
    - Register `redirect_pc` = `exc_vector` if `exc_valid`, else `ex_target`. Exception has priority.
    - Pulse `redirect_valid`.
  - In FLUSH:
    - `flush` = 1.
    - `fcnt` decrements each cycle; at 0, return to RUN.
    - A new `exc_valid` during FLUSH reloads `fcnt` and re-issues the redirect with `exc_vector`.
    - `ex_redirect` during FLUSH is ignored, since it comes from a squashed instruction.
- Stall counter:
  - Increments each cycle `stall` = 1.
  - Saturates at all-ones and does not wrap.

## Timing
- Reset values:
  - `busy_vec` = 0
  - state RUN
  - `flush` = 0
  - `redirect_valid` = 0
  - `redirect_pc` = 0
  - `stall_count` = 0
  - `stall` = 0, since the scoreboard is empty
- `stall` is combinational from the decode inputs and `busy`, with zero-cycle latency.
- `flush`, `redirect_valid` and `redirect_pc` assert the cycle after the triggering event.
- `flush` is high for exactly FLUSH_CYCLES consecutive cycles per redirect, with `redirect_valid` high only in the first of them.
- Scoreboard updates are visible the cycle after `issue` or `wb_valid`.
- Back-to-back dependent instructions: the consumer stalls from the cycle after producer issue until the cycle after producer writeback.
- `reset` mid-flush returns the FSM to RUN and clears everything on the next edge.

## Structure
- Shared package/defines:
  - Add `REG_ADDR_SIZE`-consistent register index width.
  - Add state encodings `HZ_RUN` and `HZ_FLUSH`.
- Sub-module `scoreboard`: 32-bit set/clear/bulk-clear register file with two read checks plus one rd check. The FSM, redirect mux and counter stay in `hazard_ctrl`.

## Test plan
- Issue `add x5` (writes_rd, rd=5), then a decode reading rs1=5 → `stall`=1 until the cycle after `wb_valid`/`wb_rd_addr`=5, then `issue`; `busy_vec[5]` returns to 0.
- Decode writing rd=0 with rs1=0 → no `busy` bit is set, `stall` never asserts.
- `ex_redirect`=1, `ex_target`=0x0000_0100 with FLUSH_CYCLES=2 → next cycle `redirect_valid`=1 and `redirect_pc`=0x100; `flush`=1 for 2 cycles; the decode instruction is not issued.
- `exc_valid` and `ex_redirect` in the same cycle (vector 0x8000_0000, target 0x200) → `redirect_pc`=0x8000_0000 and `busy_vec`=0.
- `exc_valid` during FLUSH → `fcnt` reloads and a second `redirect_valid` pulse is issued; `ex_redirect` during FLUSH produces no pulse.
- Hold a hazard for 2^CNT_W + 3 cycles with CNT_W=4 → `stall_count` saturates at 15; `reset` → all outputs at their reset values.
